fibo_job_scheduler: RTL and testbench
=====================================

Name: fibo_job_scheduler

Overview:
- Shares one fibonacci_calculator_project instance among NUM_REQ requesters.
- Sequences each job on the calculator: calculator reset pulse, begin_fibo pulse, wait for done, capture result.
- Returns the result on a shared response bus tagged with the requester ID.
- Sits between client logic and the calculator. The calculator is restarted through its reset for every job.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RST_CYCLES, 2, cycles calc_reset_n is held low before each job.
- BEGIN_CYCLES, 2, cycles calc_begin_fibo is held high.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before the job is aborted.
- MAX_N, 24, largest legal n (F(24)=46368 fits in 16 bits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester job request, held until accepted
- req_n  in  NUM_REQ*5  per-requester Fibonacci index
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- resp_valid  out  1  one-cycle response strobe, no backpressure
- resp_id  out  $clog2(NUM_REQ)  requester the response belongs to
- resp_data  out  16  F(n); 0 when resp_err=1
- resp_err  out  1  illegal n or timeout
- busy  out  1  high in any state other than IDLE
- calc_reset_n  out  1  calculator reset (active low)
- calc_input_s  out  5  calculator input
- calc_begin_fibo  out  1  calculator start
- calc_fibo_out  in  16  calculator result
- calc_done  in  1  calculator done (level)

Behaviour:
- Reset state: all outputs 0, state=IDLE, rr pointer=0.
- calc_reset_n = reset_n AND internal_rst_n, so the calculator is held in reset whenever the scheduler is.
- Outside the CRST state, internal_rst_n=1.
- Fibonacci convention: F(1)=1, F(2)=1, F(n)=F(n-1)+F(n-2).
- States: IDLE, CRST, START, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first asserted index at or after rr_ptr (wrapping).
  - Pulse req_ready[g] in that cycle.
  - Latch n_q=req_n[g] and id_q=g; rr_ptr <= g+1 mod NUM_REQ.
  - If n_q==0 or n_q>MAX_N: err_q=1 and go to RESP; the calculator is not touched.
  - Otherwise go to CRST with cnt=0.
- CRST: calc_reset_n=0 for RST_CYCLES cycles, then go to START.
- START:
  - calc_begin_fibo=1 for BEGIN_CYCLES cycles.
  - calc_input_s=n_q, held stable from CRST through WAIT.
  - Then go to WAIT with the timeout counter at 0.
- WAIT:
  - calc_begin_fibo=0.
  - On calc_done==1 sampled at a clock edge: data_q=calc_fibo_out, err_q=0, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without done: err_q=1, data_q=0, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_id=id_q, resp_data=data_q, resp_err=err_q. Then go to IDLE.
  - resp_* hold their last values afterwards; resp_valid=0.
- Grant timing: requests are evaluated only in IDLE, so the earliest grant after a response is the cycle following RESP.
- Fairness: with all requesters active, grants rotate 0,1,2,3,0,...
- Job latency from the accept cycle: 1 + RST_CYCLES + BEGIN_CYCLES + calc latency + 1.
- Illegal-n latency: 2 cycles (IDLE → RESP → IDLE).
- A request deasserted before acceptance is dropped silently.
- req_ready is never asserted to more than one requester at a time.
- Reset mid-job: all state is cleared immediately, calc_reset_n goes low, and no response is issued for the in-flight job.

Decomposition:
- fibo_sched_pkg holds:
  - state enum type sched_state_t {IDLE, CRST, START, WAIT, RESP};
  - constants N_W=5, FIBO_W=16, MAX_N_DEFAULT=24.
- Sub-module rr_arbiter (params NUM_REQ; ports req, ptr, gnt_onehot, gnt_idx, any) is purely combinational. The scheduler FSM owns the pointer register.

Test Plan:
- Single job: requester 0, n=5 → req_ready[0] pulse; calc_reset_n low 2 cycles; calc_begin_fibo high 2 cycles with calc_input_s=5; resp_valid with id=0, data=5, err=0.
- Back-to-back with model calculator: requester 1 n=9 then requester 1 n=12 → responses 34 then 144; calculator reset pulse precedes each job.
- Round-robin: all 4 requesters hold valid with n=1,2,3,4 → grant order 0,1,2,3; responses 1,1,2,3 with matching resp_id; rr_ptr returns to 0.
- Illegal n: n=0 and n=25 → resp_err=1, data=0, response 2 cycles after accept; calc_reset_n and calc_begin_fibo never toggle.
- Timeout: TIMEOUT_CYCLES=16 with a stub that never asserts done, n=7 → resp_err=1 exactly 16 cycles after entering WAIT; the next request is served normally.
- Reset mid-job: assert reset_n=0 during WAIT → all outputs 0 asynchronously, calc_reset_n=0, no resp_valid; after release, a new n=12 job returns 144.

Source files
------------

// File: rtl/fibo_sched_pkg.sv
// Shared types and constants for the Fibonacci job scheduler.
// Widths match the calculator's 5-bit index and 16-bit result.
package fibo_sched_pkg;

    localparam int N_W           = 5;
    localparam int FIBO_W        = 16;
    localparam int MAX_N_DEFAULT = 24;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        START,
        WAIT,
        RESP
    } sched_state_t;

endpackage

// File: rtl/fibo_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// The owner of ptr advances it past the winner after each grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fibo_job_scheduler.sv
// Time-shares one Fibonacci calculator among NUM_REQ requesters: reset pulse,
// begin pulse, wait for done, then one tagged response strobe per job.
module fibo_job_scheduler
    import fibo_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int RST_CYCLES     = 2,
    parameter int BEGIN_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_N          = MAX_N_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*N_W-1:0]       req_n,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [FIBO_W-1:0]            resp_data,
    output logic                         resp_err,
    output logic                         busy,
    output logic                         calc_reset_n,
    output logic [N_W-1:0]               calc_input_s,
    output logic                         calc_begin_fibo,
    input  logic [FIBO_W-1:0]            calc_fibo_out,
    input  logic                         calc_done
);

    localparam int ID_W      = $clog2(NUM_REQ);
    localparam int CNT_MAX_A = (RST_CYCLES > BEGIN_CYCLES) ? RST_CYCLES : BEGIN_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    sched_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [N_W-1:0]    n_q;

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [N_W-1:0]     gnt_n;
    logic               n_legal;
    logic [ID_W-1:0]    ptr_next;
    logic               internal_rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    always_comb begin
        gnt_n = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_onehot[i]) begin
                gnt_n = req_n[i*N_W +: N_W];
            end
        end
    end

    assign n_legal  = (gnt_n != '0) && (int'(gnt_n) <= MAX_N);
    assign ptr_next = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

    // The calculator is also held in reset whenever the scheduler itself is.
    assign internal_rst_n = (state != CRST);
    assign calc_reset_n   = reset_n & internal_rst_n;
    assign calc_input_s   = n_q;
    assign busy           = (state != IDLE);
    assign req_ready      = (state == IDLE && reset_n) ? gnt_onehot : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            rr_ptr          <= '0;
            id_q            <= '0;
            n_q             <= '0;
            calc_begin_fibo <= 1'b0;
            resp_valid      <= 1'b0;
            resp_id         <= '0;
            resp_data       <= '0;
            resp_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        rr_ptr <= ptr_next;
                        id_q   <= gnt_idx;
                        n_q    <= gnt_n;
                        cnt    <= '0;
                        // Illegal indices are answered without touching the calculator.
                        if (n_legal) begin
                            state <= CRST;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_id    <= gnt_idx;
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                CRST: begin
                    if (cnt == CNT_W'(RST_CYCLES-1)) begin
                        state           <= START;
                        cnt             <= '0;
                        calc_begin_fibo <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(BEGIN_CYCLES-1)) begin
                        state           <= WAIT;
                        cnt             <= '0;
                        calc_begin_fibo <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (calc_done) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_data  <= calc_fibo_out;
                        resp_err   <= 1'b0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_job_scheduler.sv
// Directed bench for fibo_job_scheduler with a behavioural calculator that answers
// CALC_LAT cycles after begin drops, or never when stub_dead is set.
module tb_fibo_job_scheduler;

    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int TIMEOUT  = 16;
    localparam int CALC_LAT = 3;
    localparam int BOUND    = 200;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*5-1:0] req_n;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic [ID_W-1:0]      resp_id;
    logic [15:0]          resp_data;
    logic                 resp_err;
    logic                 busy;
    logic                 calc_reset_n;
    logic [4:0]           calc_input_s;
    logic                 calc_begin_fibo;
    logic [15:0]          calc_fibo_out;
    logic                 calc_done;

    int checks   = 0;
    int failures = 0;

    int         crst_total  = 0;
    int         begin_total = 0;
    int         wait_total  = 0;
    int         resp_total  = 0;
    logic [4:0] begin_input = '0;
    logic       stub_dead;
    logic       running;
    int         lat_cnt;

    fibo_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .RST_CYCLES     (2),
        .BEGIN_CYCLES   (2),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_N          (24)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_n           (req_n),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_id         (resp_id),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .busy            (busy),
        .calc_reset_n    (calc_reset_n),
        .calc_input_s    (calc_input_s),
        .calc_begin_fibo (calc_begin_fibo),
        .calc_fibo_out   (calc_fibo_out),
        .calc_done       (calc_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fib(input logic [4:0] n);
        logic [15:0] a, b, t;
        a = 16'd0;
        b = 16'd1;
        for (int i = 1; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Behavioural calculator: cleared by its reset, restarted while begin is high.
    always @(posedge clk or negedge calc_reset_n) begin
        if (!calc_reset_n) begin
            calc_done     <= 1'b0;
            calc_fibo_out <= '0;
            running       <= 1'b0;
            lat_cnt       <= 0;
        end else if (calc_begin_fibo) begin
            running   <= 1'b1;
            lat_cnt   <= 0;
            calc_done <= 1'b0;
        end else if (running && !stub_dead) begin
            if (lat_cnt == CALC_LAT-1) begin
                calc_done     <= 1'b1;
                calc_fibo_out <= fib(calc_input_s);
                running       <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // Cycle counters for the calculator handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (!calc_reset_n && reset_n) crst_total <= crst_total + 1;
        if (calc_begin_fibo) begin
            begin_total <= begin_total + 1;
            begin_input <= calc_input_s;
        end
        if (busy && calc_reset_n && !calc_begin_fibo && !resp_valid) wait_total <= wait_total + 1;
        if (resp_valid) resp_total <= resp_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int id, input logic [4:0] n);
        req_n[id*5 +: 5] = n;
        req_valid[id]    = 1'b1;
    endtask

    task automatic wait_accept(input string tag, input int exp_id);
        int t = 0;
        int g = -1;
        #1;
        while (req_ready == '0 && t < BOUND) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq({tag, "_accepted"}, 32'(req_ready != '0), 1);
        check_eq({tag, "_onehot"}, $countones(req_ready), 1);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) g = i;
        end
        check_eq({tag, "_grant_id"}, g, exp_id);
        @(posedge clk); #1;
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic check_output(input string tag, input int exp_id, input int exp_data,
                                input int exp_err, input int exp_crst, input int exp_begin,
                                input int exp_lat);
        int c0, b0;
        int lat;
        c0 = crst_total;
        b0 = begin_total;
        wait_accept(tag, exp_id);
        @(negedge clk); #1;
        lat = 2;
        while (!resp_valid && lat < BOUND) begin
            @(negedge clk); #1;
            lat++;
        end
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 1);
        check_eq({tag, "_resp_id"}, 32'(resp_id), exp_id);
        check_eq({tag, "_resp_data"}, 32'(resp_data), exp_data);
        check_eq({tag, "_resp_err"}, 32'(resp_err), exp_err);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_crst_cycles"}, crst_total - c0, exp_crst);
        check_eq({tag, "_begin_cycles"}, begin_total - b0, exp_begin);
        @(negedge clk); #1;
        check_eq({tag, "_strobe_drop"}, 32'(resp_valid), 0);
        check_eq({tag, "_data_hold"}, 32'(resp_data), exp_data);
    endtask

    initial begin
        int w0, r0, t;
        reset_n   = 1'b0;
        req_valid = '0;
        req_n     = '0;
        stub_dead = 1'b0;
        repeat (3) @(negedge clk);
        req_valid[2] = 1'b1;
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_resp_valid", 32'(resp_valid), 0);
        check_eq("rst_resp_id", 32'(resp_id), 0);
        check_eq("rst_resp_data", 32'(resp_data), 0);
        check_eq("rst_resp_err", 32'(resp_err), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_calc_reset_n", 32'(calc_reset_n), 0);
        check_eq("rst_calc_begin", 32'(calc_begin_fibo), 0);
        check_eq("rst_calc_input", 32'(calc_input_s), 0);
        req_valid[2] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_calc_reset_n", 32'(calc_reset_n), 1);
        check_eq("post_rst_busy", 32'(busy), 0);

        $display("[TB] single job");
        apply_stimulus(0, 5'd5);
        check_output("single", 0, 5, 0, 2, 2, 10);
        check_eq("single_calc_input", 32'(begin_input), 5);

        $display("[TB] back-to-back jobs");
        apply_stimulus(1, 5'd9);
        check_output("b2b_9", 1, 34, 0, 2, 2, 10);
        check_eq("b2b_9_calc_input", 32'(begin_input), 9);
        apply_stimulus(1, 5'd12);
        check_output("b2b_12", 1, 144, 0, 2, 2, 10);

        $display("[TB] illegal indices");
        apply_stimulus(3, 5'd0);
        check_output("illegal_0", 3, 0, 1, 0, 0, 2);
        apply_stimulus(3, 5'd25);
        check_output("illegal_25", 3, 0, 1, 0, 0, 2);

        $display("[TB] round robin");
        apply_stimulus(0, 5'd1);
        apply_stimulus(1, 5'd2);
        apply_stimulus(2, 5'd3);
        apply_stimulus(3, 5'd4);
        check_output("rr_0", 0, 1, 0, 2, 2, 10);
        check_output("rr_1", 1, 1, 0, 2, 2, 10);
        check_output("rr_2", 2, 2, 0, 2, 2, 10);
        check_output("rr_3", 3, 3, 0, 2, 2, 10);
        apply_stimulus(3, 5'd10);
        apply_stimulus(0, 5'd10);
        check_output("wrap_0", 0, 55, 0, 2, 2, 10);
        check_output("wrap_3", 3, 55, 0, 2, 2, 10);

        $display("[TB] timeout");
        stub_dead = 1'b1;
        w0 = wait_total;
        apply_stimulus(2, 5'd7);
        check_output("timeout", 2, 0, 1, 2, 2, 22);
        check_eq("timeout_wait_cycles", wait_total - w0, TIMEOUT);
        stub_dead = 1'b0;
        apply_stimulus(3, 5'd6);
        check_output("after_timeout", 3, 8, 0, 2, 2, 10);

        $display("[TB] reset during wait");
        apply_stimulus(1, 5'd12);
        wait_accept("midrst", 1);
        t = 0;
        while (!(busy && calc_reset_n && !calc_begin_fibo) && t < BOUND) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq("midrst_reached_wait", 32'(busy && calc_reset_n && !calc_begin_fibo), 1);
        r0 = resp_total;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_calc_reset_n", 32'(calc_reset_n), 0);
        check_eq("midrst_resp_valid", 32'(resp_valid), 0);
        check_eq("midrst_resp_data", 32'(resp_data), 0);
        check_eq("midrst_resp_id", 32'(resp_id), 0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("midrst_no_response", resp_total - r0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1, 5'd12);
        check_output("post_midrst", 1, 144, 0, 2, 2, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
